// File: rtl/universal_shift_register_if.sv
// universal_shift_register_if
//
// Bundles the control, data and status signals of the universal shift
// register so that a driver and the register can be connected through one
// port. Clock and reset are not part of the bundle.
//
// Parameters:
//   WIDTH  register width in bits (>= 2)
//
// Signals:
//   en           clock enable; 0 freezes all register state
//   mode         operation select (HOLD/SHL/SHR/ROL/ROR/LOAD/CLR/reserved)
//   ser_in_r     serial bit entering the LSB on shift left
//   ser_in_l     serial bit entering the MSB on shift right
//   load_data    parallel load value
//   data_out     registered register contents
//   ser_out_msb  data_out[WIDTH-1]
//   ser_out_lsb  data_out[0]
//   bit_count    serial shifts accumulated in the current word
//   word_valid   one-cycle pulse when WIDTH serial shifts complete a word
//
// Modports:
//   master  drives the controls, observes the status
//   slave   the shift register itself
interface universal_shift_register_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             en;
  logic [2:0]       mode;
  logic             ser_in_r;
  logic             ser_in_l;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] data_out;
  logic             ser_out_msb;
  logic             ser_out_lsb;
  logic [CW-1:0]    bit_count;
  logic             word_valid;

  modport master (
    output en, mode, ser_in_r, ser_in_l, load_data,
    input  data_out, ser_out_msb, ser_out_lsb, bit_count, word_valid
  );

  modport slave (
    input  en, mode, ser_in_r, ser_in_l, load_data,
    output data_out, ser_out_msb, ser_out_lsb, bit_count, word_valid
  );
endinterface

// File: rtl/universal_shift_register.sv
// universal_shift_register
//
// Parametrised multi-mode shift register: hold, shift left/right with
// independent serial inputs, rotate left/right, parallel load and clear.
// A shift counter pulses word_valid each time WIDTH serial shifts have
// assembled a complete word, so the block doubles as a deserialiser.
//
// Parameters:
//   WIDTH  register width in bits (>= 2); must match the interface WIDTH
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset; overrides en and mode
//   bus    universal_shift_register_if.slave (controls in, status out)
module universal_shift_register #(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  universal_shift_register_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  mode_e            op;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             serial_shift;

  assign op = mode_e'(bus.mode);

  // Next-state decode. Everything defaults to "hold, no pulse", so en==0
  // and the non-counting modes simply fall through to those defaults.
  // Serial and load inputs are only looked at in the modes that use them,
  // which keeps unknowns on idle inputs out of the register.
  always_comb begin
    data_d       = data_q;
    count_d      = count_q;
    valid_d      = 1'b0;
    serial_shift = 1'b0;

    if (bus.en) begin
      case (op)
        MODE_SHL: begin
          data_d       = {data_q[WIDTH-2:0], bus.ser_in_r};
          serial_shift = 1'b1;
        end
        MODE_SHR: begin
          data_d       = {bus.ser_in_l, data_q[WIDTH-1:1]};
          serial_shift = 1'b1;
        end
        MODE_ROL: data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        MODE_ROR: data_d = {data_q[0], data_q[WIDTH-1:1]};
        MODE_LOAD: begin
          data_d  = bus.load_data;
          count_d = '0;
        end
        MODE_CLR: begin
          data_d  = '0;
          count_d = '0;
        end
        default: data_d = data_q;
      endcase

      // Both shift directions feed the same word counter; the pulse is
      // registered alongside the last shift so it lines up with the word.
      if (serial_shift) begin
        if (count_q == CW'(WIDTH - 1)) begin
          count_d = '0;
          valid_d = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low reset; a reset mid-word
  // throws away the partial count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.ser_out_msb = data_q[WIDTH-1];
  assign bus.ser_out_lsb = data_q[0];
  assign bus.bit_count   = count_q;
  assign bus.word_valid  = valid_q;
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register
//
// Drives a 4-bit and an 8-bit instance of universal_shift_register with
// directed vectors. A behavioural model (plain integer arithmetic) tracks
// each instance and is compared against the DUT on every falling edge;
// hand-computed literal expectations pin both the DUT and the model.
module tb_universal_shift_register;
  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] SHL  = 3'b001;
  localparam logic [2:0] SHR  = 3'b010;
  localparam logic [2:0] ROL  = 3'b011;
  localparam logic [2:0] ROR  = 3'b100;
  localparam logic [2:0] LOAD = 3'b101;
  localparam logic [2:0] CLR  = 3'b110;
  localparam logic [2:0] RSVD = 3'b111;

  logic clk;
  logic reset4;
  logic reset8;

  int passCount;
  int totalCount;

  // Model state, index 0 = 4-bit instance, index 1 = 8-bit instance.
  int mData  [2];
  int mCount [2];
  int mValid [2];
  bit mKnown [2];

  universal_shift_register_if #(.WIDTH(4)) ifc4 ();
  universal_shift_register_if #(.WIDTH(8)) ifc8 ();

  universal_shift_register #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (ifc4)
  );

  universal_shift_register #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset8),
    .bus   (ifc8)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else
      passCount++;
  endtask

  // Behavioural model: register value as an integer modulo 2**w, serial
  // shifts counted modulo w with a pulse on each completed word.
  task automatic modelStep(input int idx, input int w, input logic rst, input logic e,
                           input logic [2:0] m, input logic sr, input logic sl,
                           input logic [7:0] ld);
    int full;
    int top;
    bit serial;
    full   = 1 << w;
    top    = 1 << (w - 1);
    serial = 0;
    if (!rst) begin
      mData[idx]  = 0;
      mCount[idx] = 0;
      mValid[idx] = 0;
      mKnown[idx] = 1;
      return;
    end
    mValid[idx] = 0;
    if (!e) return;
    case (m)
      SHL: begin mData[idx] = (mData[idx] * 2 + int'(sr)) % full; serial = 1; end
      SHR: begin mData[idx] = mData[idx] / 2 + int'(sl) * top; serial = 1; end
      ROL: mData[idx] = (mData[idx] * 2) % full + mData[idx] / top;
      ROR: mData[idx] = mData[idx] / 2 + (mData[idx] % 2) * top;
      LOAD: begin mData[idx] = int'(ld) % full; mCount[idx] = 0; end
      CLR: begin mData[idx] = 0; mCount[idx] = 0; end
      default: ;
    endcase
    if (serial) begin
      mCount[idx] = mCount[idx] + 1;
      if (mCount[idx] == w) begin
        mCount[idx] = 0;
        mValid[idx] = 1;
      end
    end
  endtask

  // Advance both models on the same edge the DUTs update.
  always @(posedge clk) begin
    modelStep(0, 4, reset4, ifc4.en, ifc4.mode, ifc4.ser_in_r, ifc4.ser_in_l, {4'b0, ifc4.load_data});
    modelStep(1, 8, reset8, ifc8.en, ifc8.mode, ifc8.ser_in_r, ifc8.ser_in_l, ifc8.load_data);
  end

  // Continuous comparison of every output against the model once the model
  // has seen a reset and therefore knows the register contents.
  always @(negedge clk) begin
    if (mKnown[0]) begin
      check("w4 data_out",    32'(ifc4.data_out),    32'(mData[0]));
      check("w4 bit_count",   32'(ifc4.bit_count),   32'(mCount[0]));
      check("w4 word_valid",  32'(ifc4.word_valid),  32'(mValid[0]));
      check("w4 ser_out_msb", 32'(ifc4.ser_out_msb), 32'((mData[0] >> 3) & 1));
      check("w4 ser_out_lsb", 32'(ifc4.ser_out_lsb), 32'(mData[0] & 1));
    end
    if (mKnown[1]) begin
      check("w8 data_out",    32'(ifc8.data_out),    32'(mData[1]));
      check("w8 bit_count",   32'(ifc8.bit_count),   32'(mCount[1]));
      check("w8 word_valid",  32'(ifc8.word_valid),  32'(mValid[1]));
      check("w8 ser_out_msb", 32'(ifc8.ser_out_msb), 32'((mData[1] >> 7) & 1));
      check("w8 ser_out_lsb", 32'(ifc8.ser_out_lsb), 32'(mData[1] & 1));
    end
  end

  // Drive one instance for one clock edge; the other instance is left
  // disabled. Returns 1 time unit after the edge so outputs are settled.
  task automatic applyStimulus(input int w, input logic rst, input logic e, input logic [2:0] m,
                               input logic sr, input logic sl, input logic [7:0] ld);
    if (w == 4) begin
      reset4         = rst;
      ifc4.en        = e;
      ifc4.mode      = m;
      ifc4.ser_in_r  = sr;
      ifc4.ser_in_l  = sl;
      ifc4.load_data = ld[3:0];
      ifc8.en        = 1'b0;
      ifc8.mode      = HOLD;
    end else begin
      reset8         = rst;
      ifc8.en        = e;
      ifc8.mode      = m;
      ifc8.ser_in_r  = sr;
      ifc8.ser_in_l  = sl;
      ifc8.load_data = ld;
      ifc4.en        = 1'b0;
      ifc4.mode      = HOLD;
    end
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expectation, applied to both the DUT and its model.
  task automatic checkOutput(input int w, input string name, input logic [7:0] expData,
                             input int expCount, input logic expValid);
    int idx;
    idx = (w == 4) ? 0 : 1;
    if (w == 4) begin
      check({name, " data"},  32'(ifc4.data_out),   32'(expData));
      check({name, " count"}, 32'(ifc4.bit_count),  32'(expCount));
      check({name, " valid"}, 32'(ifc4.word_valid), 32'(expValid));
    end else begin
      check({name, " data"},  32'(ifc8.data_out),   32'(expData));
      check({name, " count"}, 32'(ifc8.bit_count),  32'(expCount));
      check({name, " valid"}, 32'(ifc8.word_valid), 32'(expValid));
    end
    check({name, " model data"},  32'(mData[idx]),  32'(expData));
    check({name, " model count"}, 32'(mCount[idx]), 32'(expCount));
    check({name, " model valid"}, 32'(mValid[idx]), 32'(expValid));
  endtask

  initial begin
    logic [3:0] serBits;
    logic [7:0] serBits8;
    passCount  = 0;
    totalCount = 0;
    for (int i = 0; i < 2; i++) begin
      mData[i]  = 0;
      mCount[i] = 0;
      mValid[i] = 0;
      mKnown[i] = 0;
    end
    clk    = 1'b0;
    reset4 = 1'b0;
    reset8 = 1'b0;
    ifc4.en = 1'b0; ifc4.mode = HOLD; ifc4.ser_in_r = 1'b0; ifc4.ser_in_l = 1'b0; ifc4.load_data = '0;
    ifc8.en = 1'b0; ifc8.mode = HOLD; ifc8.ser_in_r = 1'b0; ifc8.ser_in_l = 1'b0; ifc8.load_data = '0;
    $display("[TB] starting universal_shift_register bench");

    // ---------------- WIDTH = 4 ----------------
    applyStimulus(4, 0, 0, HOLD, 0, 0, 8'h0);
    applyStimulus(4, 0, 0, HOLD, 0, 0, 8'h0);
    checkOutput(4, "w4 reset", 8'h0, 0, 0);
    applyStimulus(4, 1, 0, HOLD, 0, 0, 8'h0);
    checkOutput(4, "w4 release", 8'h0, 0, 0);

    // SHL 1,1,0,1
    applyStimulus(4, 1, 1, SHL, 1, 0, 8'h0); checkOutput(4, "w4 shl1", 8'h1, 1, 0);
    applyStimulus(4, 1, 1, SHL, 1, 0, 8'h0); checkOutput(4, "w4 shl2", 8'h3, 2, 0);
    applyStimulus(4, 1, 1, SHL, 0, 1, 8'h0); checkOutput(4, "w4 shl3", 8'h6, 3, 0);
    applyStimulus(4, 1, 1, SHL, 1, 0, 8'h0); checkOutput(4, "w4 shl4", 8'hD, 0, 1);

    // LOAD, rotates
    applyStimulus(4, 1, 1, LOAD, 1, 1, 8'h9); checkOutput(4, "w4 load", 8'h9, 0, 0);
    applyStimulus(4, 1, 1, ROL, 1, 1, 8'hF);  checkOutput(4, "w4 rol1", 8'h3, 0, 0);
    applyStimulus(4, 1, 1, ROL, 0, 0, 8'hF);  checkOutput(4, "w4 rol2", 8'h6, 0, 0);
    applyStimulus(4, 1, 1, ROR, 1, 1, 8'h0);  checkOutput(4, "w4 ror1", 8'h3, 0, 0);

    // SHR from zero with an enable gap
    applyStimulus(4, 1, 1, CLR, 1, 1, 8'hF);  checkOutput(4, "w4 clr", 8'h0, 0, 0);
    applyStimulus(4, 1, 1, SHR, 0, 1, 8'h0);  checkOutput(4, "w4 shr1", 8'h8, 1, 0);
    applyStimulus(4, 1, 1, SHR, 0, 1, 8'h0);  checkOutput(4, "w4 shr2", 8'hC, 2, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4, 1, 0, SHR, i[0], ~i[0], 8'hF);
      checkOutput(4, "w4 en0", 8'hC, 2, 0);
    end
    applyStimulus(4, 1, 1, SHR, 1, 0, 8'h0);  checkOutput(4, "w4 shr3", 8'h6, 3, 0);
    applyStimulus(4, 1, 1, SHR, 1, 0, 8'h0);  checkOutput(4, "w4 shr4", 8'h3, 0, 1);
    applyStimulus(4, 1, 1, HOLD, 1, 1, 8'h0); checkOutput(4, "w4 pulse end", 8'h3, 0, 0);

    // Reset mid-word with en=1/SHL asserted
    applyStimulus(4, 1, 1, SHL, 1, 0, 8'h0);  checkOutput(4, "w4 pre1", 8'h7, 1, 0);
    applyStimulus(4, 1, 1, SHL, 1, 0, 8'h0);  checkOutput(4, "w4 pre2", 8'hF, 2, 0);
    applyStimulus(4, 0, 1, SHL, 1, 0, 8'h0);  checkOutput(4, "w4 midreset", 8'h0, 0, 0);
    serBits = 4'b0101;
    applyStimulus(4, 1, 1, SHL, serBits[0], 0, 8'h0); checkOutput(4, "w4 word1", 8'h1, 1, 0);
    applyStimulus(4, 1, 1, SHL, serBits[1], 0, 8'h0); checkOutput(4, "w4 word2", 8'h2, 2, 0);
    applyStimulus(4, 1, 1, SHR, serBits[2], 1, 8'h0); checkOutput(4, "w4 word3", 8'h9, 3, 0);
    applyStimulus(4, 1, 1, SHL, serBits[3], 0, 8'h0); checkOutput(4, "w4 word4", 8'h2, 0, 1);

    // Back-to-back words: pulse again exactly WIDTH shifts later
    for (int i = 0; i < 3; i++) applyStimulus(4, 1, 1, SHL, 1, 0, 8'h0);
    checkOutput(4, "w4 b2b3", 8'h7, 3, 0);
    applyStimulus(4, 1, 1, SHL, 1, 0, 8'h0);  checkOutput(4, "w4 b2b4", 8'hF, 0, 1);

    // Reserved / HOLD ignore serial and load inputs
    applyStimulus(4, 1, 1, RSVD, 0, 0, 8'h0); checkOutput(4, "w4 rsvd", 8'hF, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(4, 1, 1, (i < 2) ? RSVD : HOLD, i[0], i[1], 8'h5);
    checkOutput(4, "w4 hold", 8'hF, 0, 0);
    applyStimulus(4, 1, 1, SHL, 0, 0, 8'h0);  checkOutput(4, "w4 shl pre load", 8'hE, 1, 0);
    applyStimulus(4, 1, 1, LOAD, 0, 0, 8'hF); checkOutput(4, "w4 load clears cnt", 8'hF, 0, 0);
    applyStimulus(4, 1, 1, CLR, 1, 1, 8'hA);  checkOutput(4, "w4 clr from f", 8'h0, 0, 0);

    // ---------------- WIDTH = 8 ----------------
    applyStimulus(8, 0, 0, HOLD, 0, 0, 8'h0);
    applyStimulus(8, 0, 0, HOLD, 0, 0, 8'h0);
    checkOutput(8, "w8 reset", 8'h00, 0, 0);
    applyStimulus(8, 1, 1, LOAD, 1, 1, 8'hA5); checkOutput(8, "w8 load", 8'hA5, 0, 0);
    applyStimulus(8, 1, 1, ROR, 0, 0, 8'h00);  checkOutput(8, "w8 ror", 8'hD2, 0, 0);
    applyStimulus(8, 1, 1, ROL, 0, 0, 8'h00);  checkOutput(8, "w8 rol", 8'hA5, 0, 0);
    serBits8 = 8'b0100_1101;
    for (int i = 0; i < 7; i++) applyStimulus(8, 1, 1, SHL, serBits8[i], 0, 8'h00);
    checkOutput(8, "w8 shl7", 8'hD9, 7, 0);
    applyStimulus(8, 1, 1, SHL, serBits8[7], 0, 8'h00); checkOutput(8, "w8 shl8", 8'hB2, 0, 1);
    applyStimulus(8, 1, 1, HOLD, 1, 1, 8'hFF);  checkOutput(8, "w8 hold", 8'hB2, 0, 0);
    applyStimulus(8, 1, 1, SHR, 0, 1, 8'h00);   checkOutput(8, "w8 shr", 8'hD9, 1, 0);
    applyStimulus(8, 1, 1, CLR, 1, 1, 8'hFF);   checkOutput(8, "w8 clr", 8'h00, 0, 0);

    applyStimulus(8, 1, 0, HOLD, 0, 0, 8'h00);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
